deserializer_frame_dbuf: RTL

//  Parametrised successor to the fixed-length deserializer: collects BIT_WIDTH-bit samples from a
//  val/rdy stream into frames of up to N_SAMPLES words, presented as one wide val/rdy message.

---
 rtl/deserializer_frame_dbuf.sv | 119 +++++++++++
 1 files changed

// File: rtl/deserializer_frame_dbuf.sv
// Collects BIT_WIDTH-bit samples into frames of up to N_SAMPLES words (runtime length,
// early termination via recv_last) behind a one-frame output buffer.
module deserializer_frame_dbuf #(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [$clog2(N_SAMPLES):0]         cfg_len,
  input  logic                               recv_val,
  output logic                               recv_rdy,
  input  logic [BIT_WIDTH-1:0]               recv_msg,
  input  logic                               recv_last,
  output logic                               send_val,
  input  logic                               send_rdy,
  output logic [N_SAMPLES*BIT_WIDTH-1:0]     send_msg,
  output logic [$clog2(N_SAMPLES):0]         send_len
);

  localparam int LW = $clog2(N_SAMPLES) + 1;
  localparam int MW = N_SAMPLES * BIT_WIDTH;
  localparam logic [LW-1:0] NL = LW'(N_SAMPLES);

  typedef enum logic {COLLECT, PENDING} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   count_q, count_d;
  logic [LW-1:0]   len_q, len_d;
  logic [MW-1:0]   buf_q, buf_d;
  logic            send_val_q, send_val_d;
  logic [MW-1:0]   send_msg_q, send_msg_d;
  logic [LW-1:0]   send_len_q, send_len_d;

  logic [LW-1:0]   eff_len, cur_len, count_inc;
  logic            accept, complete, out_free;
  logic [MW-1:0]   buf_wr;

  assign eff_len   = (cfg_len == '0 || cfg_len > NL) ? NL : cfg_len;
  assign cur_len   = (count_q == '0) ? eff_len : len_q;
  assign count_inc = count_q + LW'(1);
  assign recv_rdy  = reset && (state_q == COLLECT);
  assign accept    = recv_val && recv_rdy;
  assign complete  = accept && (count_inc == cur_len || recv_last);
  assign out_free  = !send_val_q || send_rdy;

  always_comb begin
    buf_wr = buf_q;
    for (int unsigned k = 0; k < N_SAMPLES; k++) begin
      if (count_q == LW'(k)) buf_wr[k*BIT_WIDTH +: BIT_WIDTH] = recv_msg;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    buf_d      = buf_q;
    send_val_d = send_val_q && !send_rdy;
    send_msg_d = send_msg_q;
    send_len_d = send_len_q;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          if (count_q == '0) len_d = eff_len;
          buf_d   = buf_wr;
          count_d = count_inc;
          if (complete) begin
            if (out_free) begin
              send_msg_d = buf_wr;
              send_len_d = count_inc;
              send_val_d = 1'b1;
              buf_d      = '0;
              count_d    = '0;
            end else begin
              // count_q carries the finished frame length while parked in PENDING
              state_d = PENDING;
            end
          end
        end
      end
      PENDING: begin
        if (out_free) begin
          send_msg_d = buf_q;
          send_len_d = count_q;
          send_val_d = 1'b1;
          buf_d      = '0;
          count_d    = '0;
          state_d    = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= COLLECT;
      count_q    <= '0;
      len_q      <= '0;
      buf_q      <= '0;
      send_val_q <= 1'b0;
      send_msg_q <= '0;
      send_len_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      len_q      <= len_d;
      buf_q      <= buf_d;
      send_val_q <= send_val_d;
      send_msg_q <= send_msg_d;
      send_len_q <= send_len_d;
    end
  end

  assign send_val = send_val_q;
  assign send_msg = send_msg_q;
  assign send_len = send_len_q;

endmodule
